low_freq_generator: RTL and testbench
=====================================

// Module: low_freq_generator
// PURPOSE
//  Programmable square-wave source; the transmit-side counterpart of the low-frequency measurement path.
//  Takes a 4-digit BCD frequency request (1..9999 Hz) and converts it to binary.
//  Divides CLK_FREQ_HZ/2 by that frequency to get a half-period count, then toggles wave_out at that rate.
//  Feeds the test-signal pin driving the frequency counter input.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  system clock rate; must be >= 2*9999
//  COUNT_WIDTH  27           width of half-period quotient/counter; must hold CLK_FREQ_HZ/2
// PORTS
//  clk      in   1            clock, rising edge
//  reset    in   1            asynchronous, active-high
//  start    in   1            request new frequency; sampled only when busy=0
//  stop     in   1            halt output and abort any conversion
//  bcd_in   in   16           [15:12]=thousands .. [3:0]=units; latched on accepted start
//  busy     out  1            controller not in IDLE
//  done     out  1            1-cycle pulse: new half-period loaded
//  error    out  1            1-cycle pulse: request rejected (digit>9 or value 0)
//  running  out  1            square wave active
//  wave_out out  1            generated square wave
// BEHAVIOUR
//  Reset: all outputs 0; controller IDLE; half_period_reg=0; generator counter=0.
//  Controller FSM (state_type): IDLE, CONVERT, CHECK, DIVIDE, LOAD.
//   IDLE: start & ~stop -> latch bcd_in, clear accumulator, CONVERT.
//   CONVERT: 4 cycles, MSD first, acc = acc*10 + digit (14-bit acc).
//    Then -> CHECK.
//   CHECK: any latched digit>9 or acc==0 -> error=1, IDLE (generator untouched).
//    Otherwise -> DIVIDE.
//   DIVIDE: restoring division, one quotient bit/cycle, COUNT_WIDTH cycles.
//    Dividend = CLK_FREQ_HZ/2 (COUNT_WIDTH bits); divisor = acc.
//    Quotient truncates. Remainder register is 15 bits.
//   LOAD: pending_half = quotient, done=1, running=1, -> IDLE.
//  Latency: start accepted at edge N -> done high in cycle N+6+COUNT_WIDTH.
//   busy is high in cycles N+1 .. N+6+COUNT_WIDTH.
//  Generator (running=1): cnt increments each cycle.
//   At cnt==half_period_reg-1: wave_out toggles, cnt=0, half_period_reg<=pending_half.
//   New frequency therefore takes effect only after the current half-cycle completes; no runt pulses.
//   First load from stopped state: half_period_reg=pending_half directly, cnt=0, wave_out=0.
//   First toggle comes half_period cycles after LOAD.
//  start while busy: ignored.
//  start while running: reconfigures; old frequency continues meanwhile.
//  Rejected request while running: error pulse only; old frequency continues.
//  stop (any state): next cycle busy=0, running=0, wave_out=0, cnt=0, controller IDLE.
//   No done or error is generated.
//  stop and start in the same cycle: stop wins.
//  Reset mid-operation: immediate return to reset values.
//  Quotient is always >=1 given the CLK_FREQ_HZ constraint.
//   half_period=1 toggles every cycle.
// STRUCTURE
//  Package low_freq_gen_pkg: state_type enum, BCD_DIGITS=4, FREQ_WIDTH=14, MAX_FREQ=9999.
//  Sub-module square_wave_gen (counter, pending/active half-period, toggle, stop).
//   The controller FSM, BCD accumulator and divider stay in the top.
// TESTING (bench: CLK_FREQ_HZ=20_000, COUNT_WIDTH=14)
//  1. Assert reset mid-stream -> all outputs 0 asynchronously; idle after release.
//  2. bcd_in=16'h0100, start -> done 20 cycles later; wave_out toggles every 100 cycles (period 200).
//  3. bcd_in=16'h00A5, start -> error pulse 5 cycles after start; no done; running unchanged.
//  4. bcd_in=16'h0000, start -> error pulse; running=0, wave_out=0.
//  5. Running 16'h0100, then start 16'h0200 -> 100-cycle half-periods continue until done.
//     After the next toggle, 50-cycle half-periods; no half-period outside {100,50}.
//  6. Start 16'h9999, then stop mid-DIVIDE -> busy=0 next cycle, no done, wave_out=0.
//     Separately: 9999 run to completion -> wave_out toggles every cycle.

Source files
------------

// File: rtl/low_freq_gen_pkg.sv
`default_nettype none
//==============================================================================
// Package  : low_freq_gen_pkg
// Brief    : Shared types and constants for the low-frequency square-wave source.
// Revision : 1.0 - initial release
//==============================================================================
package low_freq_gen_pkg;

    localparam int BCD_DIGITS = 4;
    localparam int FREQ_WIDTH = 14;
    localparam int MAX_FREQ   = 9999;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CONVERT = 3'd1,
        CHECK   = 3'd2,
        DIVIDE  = 3'd3,
        LOAD    = 3'd4
    } state_type;

    // True when every nibble of the request is a legal decimal digit.
    function automatic logic bcd_valid(input logic [4*BCD_DIGITS-1:0] bcd);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (bcd[4*i +: 4] > 4'd9) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/low_freq_generator_square_wave_gen.sv
`default_nettype none
//==============================================================================
// Module   : square_wave_gen
// Brief    : Half-period counter and toggle; new periods apply at half-cycle ends.
// Revision : 1.0 - initial release
//==============================================================================
module square_wave_gen #(
    parameter int COUNT_WIDTH = 27
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_load,
    input  logic [COUNT_WIDTH-1:0] i_half,
    input  logic                   i_stop,
    output logic                   o_running,
    output logic                   o_wave
);

    localparam logic [COUNT_WIDTH-1:0] c_ONE = COUNT_WIDTH'(1);

    logic [COUNT_WIDTH-1:0] r_cnt;
    logic [COUNT_WIDTH-1:0] r_half;
    logic [COUNT_WIDTH-1:0] r_pending;
    logic                   r_running;
    logic                   r_wave;
    logic                   w_last;

    assign w_last = (r_cnt == r_half - c_ONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt     <= '0;
            r_half    <= '0;
            r_pending <= '0;
            r_running <= 1'b0;
            r_wave    <= 1'b0;
        end else if (i_stop) begin
            r_cnt     <= '0;
            r_running <= 1'b0;
            r_wave    <= 1'b0;
        end else begin
            if (i_load) begin
                r_pending <= i_half;
            end
            if (r_running) begin
                // A load coinciding with a toggle is picked up immediately.
                if (w_last) begin
                    r_wave <= ~r_wave;
                    r_cnt  <= '0;
                    r_half <= i_load ? i_half : r_pending;
                end else begin
                    r_cnt <= r_cnt + c_ONE;
                end
            end else if (i_load) begin
                r_running <= 1'b1;
                r_half    <= i_half;
                r_cnt     <= '0;
                r_wave    <= 1'b0;
            end
        end
    end

    assign o_running = r_running;
    assign o_wave    = r_wave;

endmodule
`default_nettype wire

// File: rtl/low_freq_generator.sv
`default_nettype none
//==============================================================================
// Module   : low_freq_generator
// Brief    : BCD frequency request -> half-period divider -> square-wave output.
// Revision : 1.0 - initial release
//==============================================================================
module low_freq_generator
    import low_freq_gen_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int COUNT_WIDTH = 27
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] bcd_in,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic        running,
    output logic        wave_out
);

    localparam logic [COUNT_WIDTH-1:0] c_DIVIDEND = COUNT_WIDTH'(CLK_FREQ_HZ / 2);
    localparam int                     c_REM_W    = FREQ_WIDTH + 1;
    localparam int                     c_DCNT_W   = $clog2(COUNT_WIDTH);
    localparam logic [c_DCNT_W-1:0]    c_DCNT_END = c_DCNT_W'(COUNT_WIDTH - 1);
    localparam logic [1:0]             c_DIG_END  = 2'(BCD_DIGITS - 1);

    state_type               r_state;
    state_type               w_state_next;
    logic [15:0]             r_bcd;
    logic [FREQ_WIDTH-1:0]   r_acc;
    logic [1:0]              r_digit_idx;
    logic [c_REM_W-1:0]      r_rem;
    logic [COUNT_WIDTH-1:0]  r_dvd;
    logic [COUNT_WIDTH-1:0]  r_quot;
    logic [c_DCNT_W-1:0]     r_div_cnt;

    logic [3:0]              w_digit;
    logic [FREQ_WIDTH-1:0]   w_acc_next;
    logic [c_REM_W:0]        w_rem_shift;
    logic [c_REM_W:0]        w_rem_sub;
    logic                    w_qbit;
    logic                    w_done;
    logic                    w_error;
    logic                    w_load;

    // Digits are consumed most-significant first.
    assign w_digit    = r_bcd[4*(BCD_DIGITS-1-int'(r_digit_idx)) +: 4];
    assign w_acc_next = {r_acc[FREQ_WIDTH-4:0], 3'b000}
                      + {r_acc[FREQ_WIDTH-2:0], 1'b0}
                      + {{(FREQ_WIDTH-4){1'b0}}, w_digit};

    // Restoring division step: shift in the next dividend bit, subtract if it fits.
    assign w_rem_shift = {r_rem, r_dvd[COUNT_WIDTH-1]};
    assign w_rem_sub   = w_rem_shift - {{(c_REM_W-FREQ_WIDTH+1){1'b0}}, r_acc};
    assign w_qbit      = (w_rem_shift >= {{(c_REM_W-FREQ_WIDTH+1){1'b0}}, r_acc});

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done       = 1'b0;
        w_error      = 1'b0;
        w_load       = 1'b0;
        if (stop) begin
            w_state_next = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        w_state_next = CONVERT;
                    end
                end
                CONVERT: begin
                    if (r_digit_idx == c_DIG_END) begin
                        w_state_next = CHECK;
                    end
                end
                CHECK: begin
                    if (!bcd_valid(r_bcd) || (r_acc == '0)) begin
                        w_error      = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_state_next = DIVIDE;
                    end
                end
                DIVIDE: begin
                    if (r_div_cnt == c_DCNT_END) begin
                        w_state_next = LOAD;
                    end
                end
                LOAD: begin
                    w_done       = 1'b1;
                    w_load       = 1'b1;
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bcd       <= '0;
            r_acc       <= '0;
            r_digit_idx <= '0;
            r_rem       <= '0;
            r_dvd       <= '0;
            r_quot      <= '0;
            r_div_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start && !stop) begin
                        r_bcd       <= bcd_in;
                        r_acc       <= '0;
                        r_digit_idx <= '0;
                    end
                end
                CONVERT: begin
                    r_acc       <= w_acc_next;
                    r_digit_idx <= r_digit_idx + 2'd1;
                end
                CHECK: begin
                    r_rem     <= '0;
                    r_dvd     <= c_DIVIDEND;
                    r_quot    <= '0;
                    r_div_cnt <= '0;
                end
                DIVIDE: begin
                    r_rem     <= w_qbit ? c_REM_W'(w_rem_sub) : c_REM_W'(w_rem_shift);
                    r_dvd     <= {r_dvd[COUNT_WIDTH-2:0], 1'b0};
                    r_quot    <= {r_quot[COUNT_WIDTH-2:0], w_qbit};
                    r_div_cnt <= r_div_cnt + c_DCNT_W'(1);
                end
                default: begin
                end
            endcase
        end
    end

    square_wave_gen #(
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_wave (
        .clk       (clk),
        .reset     (reset),
        .i_load    (w_load),
        .i_half    (r_quot),
        .i_stop    (stop),
        .o_running (running),
        .o_wave    (wave_out)
    );

    assign busy  = (r_state != IDLE);
    assign done  = w_done;
    assign error = w_error;

endmodule
`default_nettype wire

// File: tb/tb_low_freq_generator.sv
`default_nettype none
//==============================================================================
// Module   : tb_low_freq_generator
// Brief    : Randomised and directed bench with a transaction-level reference model.
// Revision : 1.0 - initial release
//==============================================================================
module tb_low_freq_generator;

    localparam int CLK_HZ   = 20_000;
    localparam int CW       = 14;
    localparam int DIVIDEND = CLK_HZ / 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [15:0] bcd_in = '0;
    logic        busy, done, error, running, wave_out;

    low_freq_generator #(
        .CLK_FREQ_HZ (CLK_HZ),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .stop     (stop),
        .bcd_in   (bcd_in),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .running  (running),
        .wave_out (wave_out)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    // Reference model: t counts clock edges; "interval t" is the time after edge t.
    int t = 0;
    bit a_act;
    bit a_valid;
    int a_end;
    int a_q;
    bit g_run;
    bit g_wave;
    int g_half;
    int g_rem;
    int g_pend;

    // Observation helpers.
    bit saw_done, saw_error, prev_wave;
    int n_done = 0;
    int last_half = 0;
    int last_tog = 0;

    function automatic void chk(input string name, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endfunction

    function automatic void decode(input logic [15:0] b, output bit valid, output int q);
        int v;
        v = 0;
        valid = 1'b1;
        for (int i = 3; i >= 0; i--) begin
            int d;
            d = int'(b[4*i +: 4]);
            if (d > 9) valid = 1'b0;
            v = v * 10 + d;
        end
        if (v == 0) valid = 1'b0;
        q = valid ? DIVIDEND / v : 0;
    endfunction

    function automatic void model_reset();
        a_act  = 1'b0;
        g_run  = 1'b0;
        g_wave = 1'b0;
        g_half = 0;
        g_rem  = 0;
        g_pend = 0;
    endfunction

    function automatic bit m_busy();
        return a_act && (t <= a_end);
    endfunction

    // Advance the model across one rising edge using the inputs held before it.
    function automatic void model_edge();
        bit busy_prev, load, was_run;
        busy_prev = m_busy();
        load = 1'b0;
        if (reset) begin
            model_reset();
        end else if (stop) begin
            a_act  = 1'b0;
            g_run  = 1'b0;
            g_wave = 1'b0;
        end else begin
            if (busy_prev && t == a_end && a_valid) load = 1'b1;
            was_run = g_run;
            if (g_run) begin
                g_rem--;
                if (g_rem == 0) begin
                    g_wave = ~g_wave;
                    g_half = load ? a_q : g_pend;
                    g_rem  = g_half;
                end
            end
            if (load) begin
                g_pend = a_q;
                if (!was_run) begin
                    g_run  = 1'b1;
                    g_wave = 1'b0;
                    g_half = a_q;
                    g_rem  = a_q;
                end
            end
            if (!busy_prev && start) begin
                a_act = 1'b1;
                decode(bcd_in, a_valid, a_q);
                a_end = t + 1 + (a_valid ? 5 + CW : 4);
            end
        end
        t++;
    endfunction

    // One clock: compare at the falling edge, then step the model at the rising edge.
    task automatic tick();
        logic [4:0] exp_v, got_v;
        bit last;
        @(negedge clk);
        last  = m_busy() && (t == a_end) && !stop && !reset;
        exp_v = {m_busy() && !reset, last && a_valid, last && !a_valid, g_run, g_wave};
        got_v = {busy, done, error, running, wave_out};
        chk($sformatf("outputs@%0d", t), int'(got_v), int'(exp_v));
        saw_done  = done;
        saw_error = error;
        if (done) n_done++;
        if (wave_out != prev_wave) begin
            last_half = t - last_tog;
            last_tog  = t;
            prev_wave = wave_out;
        end
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic pulse_start(input logic [15:0] b);
        bcd_in = b;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    task automatic wait_for(input bit want_done, input int maxc, output int k);
        k = 0;
        for (int i = 1; i <= maxc; i++) begin
            tick();
            if (want_done ? saw_done : saw_error) begin
                k = i;
                break;
            end
        end
    endtask

    initial begin
        int k;
        int d0;
        model_reset();
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("idle_busy", int'(busy), 0);
        chk("idle_running", int'(running), 0);

        // 100 Hz: half-period 100 cycles.
        pulse_start(16'h0100);
        wait_for(1'b1, 40, k);
        chk("done_latency", k, 20);
        repeat (450) tick();
        chk("half_100", last_half, 100);

        // Invalid digit while running.
        pulse_start(16'h00A5);
        wait_for(1'b0, 40, k);
        chk("error_latency", k, 5);
        chk("running_kept", int'(running), 1);

        // Reconfigure to 200 Hz while running.
        pulse_start(16'h0200);
        wait_for(1'b1, 40, k);
        chk("reconf_latency", k, 20);
        repeat (300) tick();
        chk("half_50", last_half, 50);

        // Stop in the middle of the divider.
        pulse_start(16'h9999);
        repeat (10) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_busy", int'(busy), 0);
        chk("stop_running", int'(running), 0);
        chk("stop_wave", int'(wave_out), 0);
        d0 = n_done;
        repeat (30) tick();
        chk("stop_no_done", n_done, d0);

        // Zero request while stopped.
        pulse_start(16'h0000);
        wait_for(1'b0, 40, k);
        chk("zero_error_latency", k, 5);
        chk("zero_running", int'(running), 0);

        // 9999 Hz: quotient 1, toggle every cycle.
        pulse_start(16'h9999);
        wait_for(1'b1, 40, k);
        chk("fast_latency", k, 20);
        repeat (8) tick();
        chk("half_1", last_half, 1);

        // Asynchronous reset mid-conversion.
        pulse_start(16'h0300);
        repeat (8) tick();
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", int'({busy, done, error, running, wave_out}), 0);
        model_reset();
        repeat (2) tick();
        reset = 1'b0;
        repeat (3) tick();

        // Randomised requests, including illegal digits, zeros and stray stops.
        for (int i = 0; i < 40; i++) begin
            logic [15:0] b;
            int r;
            r = $urandom_range(0, 99);
            for (int j = 0; j < 4; j++) b[4*j +: 4] = 4'($urandom_range(0, 9));
            if (r < 10) b[4*$urandom_range(0, 3) +: 4] = 4'($urandom_range(10, 15));
            else if (r < 15) b = 16'h0000;
            else if (r < 40) b[15:8] = 8'h00;
            bcd_in = b;
            start  = 1'b1;
            stop   = ($urandom_range(0, 9) == 0);
            tick();
            start  = 1'b0;
            stop   = 1'b0;
            repeat ($urandom_range(1, 70)) begin
                stop = ($urandom_range(0, 49) == 0);
                tick();
                stop = 1'b0;
            end
        end
        repeat (40) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
